// File: rtl/circuit2_driver_if.sv
// Handshake bundle between the operand producer, the datapath and the result consumer.
// master is the sequencer side; slave is the environment (producer, datapath, consumer).
interface circuit2_driver_if #(
  parameter int DATAW = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] in_a;
  logic [DATAW-1:0] in_b;
  logic [DATAW-1:0] in_c;
  logic [DATAW-1:0] dp_a;
  logic [DATAW-1:0] dp_b;
  logic [DATAW-1:0] dp_c;
  logic [DATAW-1:0] dp_x;
  logic [DATAW-1:0] dp_z;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_x;
  logic [DATAW-1:0] out_z;
  logic [CW-1:0]    out_count;
  logic             busy;

  modport master (
    input  in_valid, in_a, in_b, in_c, dp_x, dp_z, out_ready,
    output in_ready, dp_a, dp_b, dp_c, out_valid, out_x, out_z, out_count, busy
  );

  modport slave (
    output in_valid, in_a, in_b, in_c, dp_x, dp_z, out_ready,
    input  in_ready, dp_a, dp_b, dp_c, out_valid, out_x, out_z, out_count, busy
  );
endinterface

// File: rtl/circuit2_driver.sv
// Issues one operand triple at a time to a LAT-cycle registered datapath and queues (x, z) results
// in a DEPTH-entry FIFO; accept-to-result latency LAT+2, in_ready held low while busy or FIFO full.
module circuit2_driver #(
  parameter int DATAW = 32,
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input logic               Clk,
  input logic               Rst,
  circuit2_driver_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAPT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TW-1:0]    wcnt;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [DATAW-1:0] mem_x [DEPTH];
  logic [DATAW-1:0] mem_z [DEPTH];
  logic             full;
  logic             accept;
  logic             push;
  logic             pop;

  assign full          = (count == CW'(DEPTH));
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_valid = (count != '0);
  assign bus.out_x     = mem_x[rptr];
  assign bus.out_z     = mem_z[rptr];
  assign bus.out_count = count;
  assign bus.busy      = (state != S_IDLE);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Rst gates in_ready so the producer never sees a ready while the block is held in reset.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    push         = 1'b0;
    bus.in_ready = 1'b0;
    unique case (state)
      S_IDLE: begin
        bus.in_ready = Rst && !full;
        accept       = bus.in_valid && Rst && !full;
        if (accept) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt == TW'(1)) begin
          state_nxt = S_CAPT;
        end
      end
      S_CAPT: begin
        push      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wcnt <= '0;
    end else if (accept) begin
      wcnt <= TW'(LAT);
    end else if (state == S_WAIT) begin
      wcnt <= wcnt - TW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      bus.dp_a <= '0;
      bus.dp_b <= '0;
      bus.dp_c <= '0;
    end else if (accept) begin
      bus.dp_a <= bus.in_a;
      bus.dp_b <= bus.in_b;
      bus.dp_c <= bus.in_c;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_x[i] <= '0;
        mem_z[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_x[wptr] <= bus.dp_x;
        mem_z[wptr] <= bus.dp_z;
        wptr        <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Admission is gated on !full and only one op is in flight, so a capture always has room.
  a_no_overflow: assert property (@(posedge Clk) disable iff (!Rst) push |-> !full);

endmodule

// File: tb/tb_circuit2_driver.sv
// Directed bench for circuit2_driver with a registered compare/shift datapath model (LAT=1).
module tb_circuit2_driver;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  circuit2_driver_if #(.DATAW(32), .DEPTH(4)) bus ();

  circuit2_driver #(.DATAW(32), .DEPTH(4), .LAT(1)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] dp_fn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [31:0] d, e, f, g, h, x, z;
    d = a + b;
    e = a + c;
    f = a - b;
    g = (d < e) ? e : d;
    h = (d == e) ? f : g;
    x = g << (d < e);
    z = h >> (d == e);
    return {x, z};
  endfunction

  always @(posedge clk) {bus.dp_x, bus.dp_z} <= dp_fn(bus.dp_a, bus.dp_b, bus.dp_c);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a triple, waits (bounded) for in_ready, and returns in the first cycle after the accept.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_c = c;
    bus.in_valid = 1'b1;
    #1;
    for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) step();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready_timeout in_ready=%b expected=1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_hold in_ready=%b out_count=%0d expected 0/0", bus.in_ready, bus.out_count);
    end
    rst = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_count !== 3'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release in_ready=%b out_count=%0d busy=%b expected 1/0/0",
               bus.in_ready, bus.out_count, bus.busy);
    end
    issue(32'd5, 32'd3, 32'd1);
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_x !== 32'd8) begin
      failures++;
      $display("FAIL reset_preload out_valid=%b out_x=%0h expected 1/8", bus.out_valid, bus.out_x);
    end
    #2;
    rst = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = $urandom;
    bus.in_b      = $urandom;
    bus.in_c      = $urandom;
    bus.out_ready = 1'($urandom);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_count !== 3'd0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_ctrl busy=%b out_valid=%b out_count=%0d in_ready=%b expected all 0",
               bus.busy, bus.out_valid, bus.out_count, bus.in_ready);
    end
    checks++;
    if (bus.dp_a !== 32'd0 || bus.dp_b !== 32'd0 || bus.dp_c !== 32'd0 ||
        bus.out_x !== 32'd0 || bus.out_z !== 32'd0) begin
      failures++;
      $display("FAIL reset_async_data dp_a=%0h dp_b=%0h dp_c=%0h out_x=%0h out_z=%0h expected all 0",
               bus.dp_a, bus.dp_b, bus.dp_c, bus.out_x, bus.out_z);
    end
    step();
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_after in_ready=%b out_count=%0d expected 1/0", bus.in_ready, bus.out_count);
    end
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    issue(32'd1, 32'd2, 32'd4);
    checks++;
    if (bus.busy !== 1'b1 || bus.dp_a !== 32'd1 || bus.dp_b !== 32'd2 || bus.dp_c !== 32'd4) begin
      failures++;
      $display("FAIL single_wait busy=%b dp=%0h/%0h/%0h expected 1, 1/2/4", bus.busy, bus.dp_a, bus.dp_b, bus.dp_c);
    end
    step();
    checks++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.dp_a !== 32'd1) begin
      failures++;
      $display("FAIL single_capt busy=%b out_valid=%b dp_a=%0h expected 1/0/1", bus.busy, bus.out_valid, bus.dp_a);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_x !== 32'd10 || bus.out_z !== 32'd5) begin
      failures++;
      $display("FAIL single_result busy=%b out_valid=%b out_x=%0h out_z=%0h expected 0/1/a/5",
               bus.busy, bus.out_valid, bus.out_x, bus.out_z);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_count !== 3'd0) begin
      failures++;
      $display("FAIL single_pop out_valid=%b out_count=%0d expected 0/0", bus.out_valid, bus.out_count);
    end
  endtask

  task automatic test_equality();
    bus.out_ready = 1'b1;
    issue(32'd2, 32'd3, 32'd3);
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_x !== 32'd5 || bus.out_z !== 32'h7FFF_FFFF) begin
      failures++;
      $display("FAIL equal_case out_valid=%b out_x=%0h out_z=%0h expected 1/5/7fffffff",
               bus.out_valid, bus.out_x, bus.out_z);
    end
    step();
    issue(32'd5, 32'd3, 32'd1);
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_x !== 32'd8 || bus.out_z !== 32'd8) begin
      failures++;
      $display("FAIL greater_case out_valid=%b out_x=%0h out_z=%0h expected 1/8/8",
               bus.out_valid, bus.out_x, bus.out_z);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_x [4];
    logic [31:0] exp_z [4];
    logic [2:0]  exp_n [4];
    exp_x = '{32'd5, 32'd8, 32'd4, 32'd60};
    exp_z = '{32'h7FFF_FFFF, 32'd8, 32'd1, 32'd30};
    exp_n = '{3'd3, 3'd2, 3'd1, 3'd1};
    bus.out_ready = 1'b0;
    issue(32'd1, 32'd2, 32'd4);
    issue(32'd2, 32'd3, 32'd3);
    issue(32'd5, 32'd3, 32'd1);
    issue(32'd3, 32'd1, 32'd1);
    step();
    step();
    bus.in_a = 32'd10;
    bus.in_b = 32'd0;
    bus.in_c = 32'd20;
    bus.in_valid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.out_count !== 3'd4 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL bp_full cyc=%0d out_count=%0d in_ready=%b busy=%b expected 4/0/0",
                 i, bus.out_count, bus.in_ready, bus.busy);
      end
      step();
    end
    checks++;
    if (bus.out_x !== 32'd10 || bus.out_z !== 32'd5) begin
      failures++;
      $display("FAIL bp_head0 out_x=%0h out_z=%0h expected a/5", bus.out_x, bus.out_z);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 1) bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_x !== exp_x[i] || bus.out_z !== exp_z[i] ||
          bus.out_count !== exp_n[i]) begin
        failures++;
        $display("FAIL bp_drain cyc=%0d out_valid=%b out_x=%0h out_z=%0h count=%0d expected 1/%0h/%0h/%0d",
                 i, bus.out_valid, bus.out_x, bus.out_z, bus.out_count, exp_x[i], exp_z[i], exp_n[i]);
      end
      if (i == 0) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          failures++;
          $display("FAIL bp_fifth_accept in_ready=%b expected 1", bus.in_ready);
        end
      end
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_count !== 3'd0) begin
      failures++;
      $display("FAIL bp_empty out_valid=%b out_count=%0d expected 0/0", bus.out_valid, bus.out_count);
    end
  endtask

  task automatic test_simul();
    bus.out_ready = 1'b0;
    issue(32'd2, 32'd3, 32'd3);
    step();
    step();
    issue(32'd1, 32'd2, 32'd4);
    step();
    checks++;
    if (bus.busy !== 1'b1 || bus.out_count !== 3'd1 || bus.out_x !== 32'd5) begin
      failures++;
      $display("FAIL simul_pre busy=%b out_count=%0d out_x=%0h expected 1/1/5", bus.busy, bus.out_count, bus.out_x);
    end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_count !== 3'd1 || bus.out_x !== 32'd10 || bus.out_z !== 32'd5) begin
      failures++;
      $display("FAIL simul_pushpop out_count=%0d out_x=%0h out_z=%0h expected 1/a/5",
               bus.out_count, bus.out_x, bus.out_z);
    end
    step();
    checks++;
    if (bus.out_count !== 3'd0) begin
      failures++;
      $display("FAIL simul_drain out_count=%0d expected 0", bus.out_count);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_wait();
    bus.out_ready = 1'b1;
    issue(32'd7, 32'd1, 32'd2);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstwait_async busy=%b out_valid=%b expected 0/0", bus.busy, bus.out_valid);
    end
    step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL rstwait_no_result cyc=%0d out_valid=%b busy=%b expected 0/0", i, bus.out_valid, bus.busy);
      end
    end
    issue(32'd1, 32'd2, 32'd4);
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_x !== 32'd10 || bus.out_z !== 32'd5) begin
      failures++;
      $display("FAIL rstwait_next out_valid=%b out_x=%0h out_z=%0h expected 1/a/5",
               bus.out_valid, bus.out_x, bus.out_z);
    end
    step();
  endtask

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_c      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_equality();
    test_backpressure();
    test_simul();
    test_reset_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/circuit2_driver.md
# circuit2_driver

Sequencing front-end for the team's registered three-operand compare/shift datapath: accepts operand triples (a, b, c) over a valid/ready handshake, drives them to the datapath, waits out the datapath's register latency, captures the (x, z) result pair and returns it through a DEPTH-entry result FIFO with its own valid/ready handshake. Sits between a producer of operand triples and a consumer of results, so neither side has to track datapath timing. One operation is in flight at a time; results are returned strictly in issue order.

## Interface
- DATAW, 32, operand/result width
- DEPTH, 4, result FIFO entries (power of two, ≥2)
- LAT, 1, datapath register latency in cycles, from dp_a/b/c stable to dp_x/z valid (≥1)

- Clk  in  1  clock, all state on rising edge
- Rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand triple valid
- in_ready  out  1  block can accept a triple this cycle
- in_a, in_b, in_c  in  DATAW each  operands
- dp_a, dp_b, dp_c  out  DATAW each  registered operands to datapath
- dp_x, dp_z  in  DATAW each  datapath results
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head this cycle
- out_x, out_z  out  DATAW each  FIFO head result
- out_count  out  clog2(DEPTH+1)  FIFO fill level
- busy  out  1  operation in flight (state ≠ IDLE)

## Operation
- FSM states: IDLE, WAIT, CAPT.
- IDLE: in_ready = (out_count < DEPTH). On in_valid & in_ready: latch in_a/b/c into dp_a/b/c, load wait counter with LAT, go WAIT. Otherwise stay.
- WAIT: in_ready = 0; decrement counter each cycle; when counter reaches 1, go CAPT next cycle (WAIT lasts exactly LAT cycles).
- CAPT: in_ready = 0; push {dp_x, dp_z} into FIFO at end of cycle; go IDLE.
- dp_a/b/c hold their value until the next accept; never change in WAIT/CAPT.
- FIFO: circular buffer, read/write pointers wrap modulo DEPTH; out_valid = (out_count ≠ 0); out_x/out_z = head entry; pop on out_valid & out_ready.
- Push in CAPT never overflows: accept only occurs with out_count < DEPTH and no other push can occur before CAPT.
- Simultaneous push and pop: out_count unchanged, both pointers advance; pop of popped entry and push of new entry both take effect.
- out_ready with out_valid = 0: ignored, no pointer/count change.
- in_valid outside IDLE or with FIFO full: not accepted; producer must hold triple stable until in_ready.

## Timing
- Reset (Rst low, asynchronous): state IDLE, counter 0, FIFO pointers 0, out_count 0, out_valid 0, busy 0, in_ready 0 while Rst low, dp_a/b/c = 0, out_x/out_z = 0. Reset mid-operation discards the in-flight triple and flushes the FIFO; no result is produced for it.
- First cycle after Rst release: in_ready = 1.
- Accept in cycle N → dp_a/b/c valid from N+1 → CAPT in cycle N+1+LAT → out_valid (if FIFO previously empty) in N+2+LAT. LAT=1: 3-cycle accept-to-result latency.
- Throughput: one accept per LAT+2 cycles (next accept at earliest N+2+LAT).
- Pop visible next cycle: out_count decrements and head advances at the edge ending the pop cycle.

## Test plan
Bench datapath model (LAT=1, registered): d=a+b, e=a+c, f=a−b (mod 2^32); g = d<e ? e : d; h = d==e ? f : g; x = g << (d<e); z = h >> (d==e).
- Reset: drive Rst low mid-cycle with random inputs → all outputs 0 immediately; after release in_ready=1, out_count=0.
- Single op a=1, b=2, c=4, out_ready=1 → out_valid exactly 3 cycles after accept, out_x=10, out_z=5; busy high for 2 cycles.
- Equality case a=2, b=3, c=3 → out_x=5, out_z=0x7FFFFFFF; case a=5, b=3, c=1 → out_x=8, out_z=8.
- Backpressure: out_ready=0, issue 4 triples → out_count=4, in_ready=0 with 5th triple held; raise out_ready → 4 results in issue order, 5th accepted on the cycle after out_count drops to 3, pointers wrap correctly.
- Simultaneous push/pop: out_count=1, out_ready=1 during CAPT → out_count stays 1, head becomes new result next cycle.
- Reset in WAIT: assert Rst one cycle after accept → busy=0, out_valid=0; no result ever emitted for that triple; next op after release returns correct result.
